mem_port_arbiter: RTL

- Shares one single-ported synchronous memory between two requesters: the instruction-fetch port (read-only) and the load/store data port (read/write).
- Sits between the microsequencer-driven datapath and the memory array.
- Each port's ready pulse is the mem_ready that holds the microsequencer in a chip-select state until the access finishes.
- Arbitration is two-way round-robin; memory latency is a fixed, parameterised wait count.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_rr_arb2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and widths for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_e;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rtl/mem_port_arbiter_rr_arb2.sv - two-way round-robin grant, one-hot, purely combinational
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  grant_e     last_grant,
    input  logic       enable,
    output logic [1:0] gnt
);

    // bit 0 is the fetch port, bit 1 the data port
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = (last_grant == GNT_IF) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and load/store ports
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_CYCLES[WAIT_W-1:0];

    state_e              state_q, state_d;
    grant_e              grant_q, grant_d;
    grant_e              last_grant_q, last_grant_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         d_rdata_q, d_rdata_d;
    logic [1:0]          gnt;

    // byte-lane and out-of-range address bits play no part in the word address
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_W+2],
                                d_addr[1:0], d_addr[31:ADDR_W+2]};

    rr_arb2 u_rr_arb2 (
        .req        ({d_req, if_req}),
        .last_grant (last_grant_q),
        .enable     (state_q == ST_IDLE),
        .gnt        (gnt)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    if (gnt[1]) begin
                        grant_d = GNT_D;
                        addr_d  = d_addr[ADDR_W+1:2];
                        we_d    = d_we;
                        be_d    = d_be;
                        wdata_d = d_wdata;
                    end else begin
                        grant_d = GNT_IF;
                        addr_d  = if_addr[ADDR_W+1:2];
                        we_d    = 1'b0;
                        be_d    = 4'b1111;
                        wdata_d = '0;
                    end
                    last_grant_d = grant_d;
                    cnt_d        = WAIT_INIT;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!we_q) begin
                        if (grant_q == GNT_D) d_rdata_d  = mem_rdata;
                        else                  if_rdata_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_IF;
            last_grant_q <= GNT_IF;
            cnt_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // memory-side outputs are forced to zero whenever no access is in flight
    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_be    = mem_en ? be_q    : '0;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;

    assign if_ready  = (state_q == ST_DONE) && (grant_q == GNT_IF);
    assign d_ready   = (state_q == ST_DONE) && (grant_q == GNT_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
